// File: rtl/rate_tick_counter_pkg.sv
// rtl/rate_tick_counter_pkg.sv - shared rate constants and counter action encoding
package rate_tick_counter_pkg;

    // div_value settings for a 50 MHz clock; RATE_0P25HZ needs DIV_W >= 28
    localparam int RATE_FULL   = 0;
    localparam int RATE_1HZ    = 49_999_999;
    localparam int RATE_0P5HZ  = 99_999_999;
    localparam int RATE_0P25HZ = 199_999_999;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_UP,
        ACT_DOWN
    } cnt_act_e;

endpackage

// File: rtl/rate_tick_counter_if.sv
// rtl/rate_tick_counter_if.sv - control and status bundle of the rate tick counter
interface rate_tick_counter_if #(
    parameter int DIV_W = 28,
    parameter int CNT_W = 4
);
    logic             enable;
    logic [DIV_W-1:0] div_value;
    logic             up_down;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             tick;
    logic [CNT_W-1:0] q;
    logic             wrap;

    modport master (
        output enable, div_value, up_down, load, load_value,
        input  tick, q, wrap
    );

    modport slave (
        input  enable, div_value, up_down, load, load_value,
        output tick, q, wrap
    );
endinterface

// File: rtl/rate_tick_counter_rate_divider.sv
// rtl/rate_tick_counter_rate_divider.sv - programmable down-counting divider with registered tick
module rate_divider #(
    parameter int DIV_W = 28
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    output logic             tick_next,
    output logic             tick
);
    logic [DIV_W-1:0] dcount;

    always_comb begin
        tick_next = enable && (dcount == '0);
    end

    // div_value is only sampled on reload, so a mid-period change waits for the next period
    always_ff @(posedge clock) begin
        if (clear) begin
            dcount <= div_value;
            tick   <= 1'b0;
        end else begin
            tick <= tick_next;
            if (enable) begin
                if (dcount == '0) begin
                    dcount <= div_value;
                end else begin
                    dcount <= dcount - DIV_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/rate_tick_counter.sv
// rtl/rate_tick_counter.sv - rate divider feeding a loadable up/down modulo counter with wrap pulse
import rate_tick_counter_pkg::*;

module rate_tick_counter #(
    parameter int DIV_W   = 28,
    parameter int CNT_W   = 4,
    parameter int CNT_MAX = 15
) (
    input  logic          clock,
    input  logic          clear,
    rate_tick_counter_if.slave bus
);
    localparam logic [CNT_W-1:0] QMAX = CNT_W'(CNT_MAX);

    logic             tick_next;
    cnt_act_e         act;
    logic [CNT_W-1:0] q_r;
    logic             wrap_r;

    rate_divider #(
        .DIV_W(DIV_W)
    ) u_divider (
        .clock     (clock),
        .clear     (clear),
        .enable    (bus.enable),
        .div_value (bus.div_value),
        .tick_next (tick_next),
        .tick      (bus.tick)
    );

    // load swallows a coincident step; the divider still reloads and ticks on its own
    always_comb begin
        act = ACT_HOLD;
        if (bus.load) begin
            act = ACT_LOAD;
        end else if (tick_next) begin
            act = bus.up_down ? ACT_UP : ACT_DOWN;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (act)
                ACT_LOAD: q_r <= (bus.load_value > QMAX) ? QMAX : bus.load_value;
                ACT_UP: begin
                    if (q_r == QMAX) begin
                        q_r    <= '0;
                        wrap_r <= 1'b1;
                    end else begin
                        q_r <= q_r + CNT_W'(1);
                    end
                end
                ACT_DOWN: begin
                    if (q_r == '0) begin
                        q_r    <= QMAX;
                        wrap_r <= 1'b1;
                    end else begin
                        q_r <= q_r - CNT_W'(1);
                    end
                end
                default: q_r <= q_r;
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_rate_tick_counter.sv
// tb/tb_rate_tick_counter.sv - vector table and scoreboard bench for rate_tick_counter
module tb_rate_tick_counter;
    localparam int DIV_W   = 28;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 9;

    logic clock50M = 1'b0;
    logic clear;

    always #10 clock50M = ~clock50M;

    rate_tick_counter_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    rate_tick_counter #(
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .clock (clock50M),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic             clear;
        logic             enable;
        logic [DIV_W-1:0] div_value;
        logic             up_down;
        logic             load;
        logic [CNT_W-1:0] load_value;
        logic             tick;
        logic [CNT_W-1:0] q;
        logic             wrap;
        string            name;
    } vec_t;

    typedef struct {
        logic             tick;
        logic [CNT_W-1:0] q;
        logic             wrap;
        string            name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(input int c, input int en, input int dv, input int ud,
                                input int ld, input int lv, input int et, input int eq,
                                input int ew, input string nm);
        vec_t v;
        v.clear      = 1'(c);
        v.enable     = 1'(en);
        v.div_value  = DIV_W'(dv);
        v.up_down    = 1'(ud);
        v.load       = 1'(ld);
        v.load_value = CNT_W'(lv);
        v.tick       = 1'(et);
        v.q          = CNT_W'(eq);
        v.wrap       = 1'(ew);
        v.name       = nm;
        return v;
    endfunction

    // drive on the falling edge, queue the expectation, compare 1 ns after the rising edge
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clock50M);
        clear          = v.clear;
        bus.enable     = v.enable;
        bus.div_value  = v.div_value;
        bus.up_down    = v.up_down;
        bus.load       = v.load;
        bus.load_value = v.load_value;
        e.tick = v.tick;
        e.q    = v.q;
        e.wrap = v.wrap;
        e.name = v.name;
        sb.push_back(e);
        @(posedge clock50M);
        #1;
        got = sb.pop_front();
        checks++;
        if (bus.tick === got.tick && bus.q === got.q && bus.wrap === got.wrap) begin
            passed++;
        end else begin
            $display("FAIL %s: got tick=%0b q=%0d wrap=%0b, expected tick=%0b q=%0d wrap=%0b",
                     got.name, bus.tick, bus.q, bus.wrap, got.tick, got.q, got.wrap);
        end
    endtask

    initial begin
        clear          = 1'b0;
        bus.enable     = 1'b0;
        bus.div_value  = '0;
        bus.up_down    = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = '0;

        // basic: period 4, q steps on edges 4, 8, 12
        vecs.push_back(mk(1, 0, 3, 1, 0, 0, 0, 0, 0, "A_clear"));
        for (int e = 1; e <= 12; e++)
            vecs.push_back(mk(0, 1, 3, 1, 0, 0, (e % 4 == 0) ? 1 : 0, e / 4, 0,
                              $sformatf("A_edge%0d", e)));

        // full rate, wrap up at 9->0, then down wrap 0->9
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, "B_clear"));
        for (int e = 1; e <= 9; e++)
            vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, e, 0, $sformatf("B_up%0d", e)));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 1, "B_wrap_up"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 1, "B_wrap_down"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 8, 0, "B_down8"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, "B_down7"));

        // load clamp, load against terminal count, load at the limit
        vecs.push_back(mk(0, 0, 0, 1, 1, 12, 0, 9, 0, "C_clamp"));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4,  1, 4, 0, "C_load_tc"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 9,  0, 9, 0, "C_load_max"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 1, "C_wrap_after_load"));

        // clear mid-period beats a simultaneous load and reloads from div_value
        vecs.push_back(mk(1, 0, 3, 1, 0, 0, 0, 0, 0, "D_clear"));
        vecs.push_back(mk(0, 0, 3, 1, 1, 5, 0, 5, 0, "D_load5"));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 5, 0, "D_step_dc2"));
        vecs.push_back(mk(1, 1, 2, 1, 1, 7, 0, 0, 0, "D_clear_beats_load"));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, "D_after1"));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, "D_after2"));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 1, 1, 0, "D_after3"));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // enable pause freezes the period position
        apply(mk(1, 0, 4, 1, 0, 0, 0, 0, 0, "E_clear"));
        for (int i = 1; i <= 2; i++)
            apply(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, $sformatf("E_run%0d", i)));
        for (int i = 0; i < 10; i++)
            apply(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, $sformatf("E_paused%0d", i)));
        for (int i = 1; i <= 3; i++)
            apply(mk(0, 1, 4, 1, 0, 0, (i == 3) ? 1 : 0, (i == 3) ? 1 : 0, 0,
                     $sformatf("E_resume%0d", i)));

        // full rate drops tick as soon as enable goes low
        apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, "E2_clear"));
        apply(mk(0, 1, 0, 1, 0, 0, 1, 1, 0, "E2_full_rate"));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, "E2_disabled"));

        // div_value 9 -> 2 mid-period: ticks at edges 10, 13, 16
        apply(mk(1, 0, 9, 1, 0, 0, 0, 0, 0, "F_clear"));
        for (int e = 1; e <= 16; e++) begin
            int et;
            int eq;
            et = (e == 10 || e == 13 || e == 16) ? 1 : 0;
            eq = ((e >= 10) ? 1 : 0) + ((e >= 13) ? 1 : 0) + ((e >= 16) ? 1 : 0);
            apply(mk(0, 1, (e <= 5) ? 9 : 2, 1, 0, 0, et, eq, 0, $sformatf("F_edge%0d", e)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
